// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD adder family.
// Both the digit-serial and the wide combinational adder import this package.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add-and-correct step.
// Invalid input digits still go through the same correction so the result is deterministic.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               ci,
  output logic [DIGIT_W-1:0] d,
  output logic               co,
  output logic               bad
);

  logic [DIGIT_W:0] s;

  always_comb begin
    s   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, ci};
    co  = s > {1'b0, BCD_MAX};
    // (s - 10) truncated to a nibble equals the low nibble minus 10, modulo 16
    d   = co ? (s[DIGIT_W-1:0] - BCD_RADIX[DIGIT_W-1:0]) : s[DIGIT_W-1:0];
    bad = digit_bad(a_d) || digit_bad(b_d);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per clock from LSD to MSD, valid/ready on both sides.
// Low-area alternative to the wide combinational adder when DIGITS-cycle latency is acceptable.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGITS*DIGIT_W-1:0] a,
  input  logic [DIGITS*DIGIT_W-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGITS*DIGIT_W-1:0] sum,
  output logic                      cout,
  output logic                      err
);

  localparam int W     = DIGITS * DIGIT_W;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT_W-1:0] dig;
  logic               dig_co;
  logic               dig_bad;

  bcd_digit_add u_digit_add (
    .a_d (opa_q[DIGIT_W-1:0]),
    .b_d (opb_q[DIGIT_W-1:0]),
    .ci  (carry_q),
    .d   (dig),
    .co  (dig_co),
    .bad (dig_bad)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          opa_d      = a;
          opb_d      = b;
          carry_d    = cin;
          idx_d      = '0;
          err_d      = 1'b0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> DIGIT_W;
        opb_d   = opb_q >> DIGIT_W;
        // New digit enters at the MSD end; after DIGITS steps the LSD sits at [3:0]
        sum_d   = W'({dig, sum_q} >> DIGIT_W);
        carry_d = dig_co;
        err_d   = err_q | dig_bad;
        if (idx_q == IDX_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign err       = err_q;

endmodule
